// File: rtl/duty_cycle_meter.sv
// duty_cycle_meter: receive-side monitor for divided clocks.
// Measures the period and high time of sig_in in clockin cycles, flags a
// match against the expected ratio, and flags a timeout if sig_in stops
// toggling. sig_in is asynchronous and passes through a 2-flop synchroniser
// plus one history flop for edge detection.
module duty_cycle_meter #(
   parameter int CNT_W      = 8,
   parameter int TIMEOUT    = 64,
   parameter int EXP_PERIOD = 5,
   parameter int EXP_HIGH   = 2
) (
   input  logic             clockin,
   input  logic             reset,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             match,
   output logic             timeout
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TIMEOUT_M1_C = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] EXP_PER_C    = CNT_W'(EXP_PERIOD);
   localparam logic [CNT_W-1:0] EXP_HIGH_C   = CNT_W'(EXP_HIGH);
   localparam logic [CNT_W-1:0] CNT_MAX_C    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ONE_C        = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             s1_r;
   logic             s2_r;
   logic             s3_r;
   logic             rise_s;
   logic             fall_s;
   logic             timeout_hit_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] idle_r;
   logic [CNT_W-1:0] h_lat_r;
   state_t           state_r;

   // Synchronise sig_in and keep one extra stage of history for edge detection
   always_ff @(posedge clockin) begin
      if (reset) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
         s3_r <= 1'b0;
      end else begin
         s1_r <= sig_in;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   // Edge detect on the synchronised signal and spot the last edgeless cycle before timeout
   always_comb begin
      rise_s        = s2_r & ~s3_r;
      fall_s        = ~s2_r & s3_r;
      timeout_hit_s = 1'b0;
      if (!rise_s && !fall_s && (idle_r == TIMEOUT_M1_C)) begin
         timeout_hit_s = 1'b1;
      end else begin
         timeout_hit_s = 1'b0;
      end
   end

   // Cycles since last rise (saturating as a guard) and cycles since any edge (saturating at TIMEOUT)
   always_ff @(posedge clockin) begin
      if (reset) begin
         cnt_r  <= {CNT_W{1'b0}};
         idle_r <= {CNT_W{1'b0}};
      end else begin
         if (rise_s) begin
            cnt_r <= ONE_C;
         end else if (cnt_r != CNT_MAX_C) begin
            cnt_r <= cnt_r + ONE_C;
         end else begin
            cnt_r <= cnt_r;
         end
         if (rise_s || fall_s) begin
            idle_r <= {CNT_W{1'b0}};
         end else if (idle_r != TIMEOUT_C) begin
            idle_r <= idle_r + ONE_C;
         end else begin
            idle_r <= idle_r;
         end
      end
   end

   // Measurement FSM: arm on a rise, latch high time on fall, publish on the next rise
   always_ff @(posedge clockin) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         h_lat_r   <= {CNT_W{1'b0}};
         period    <= {CNT_W{1'b0}};
         high_time <= {CNT_W{1'b0}};
         valid     <= 1'b0;
         match     <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (rise_s) begin
                  state_r <= ST_HIGH;
                  timeout <= 1'b0;
               end
            end
            ST_HIGH: begin
               if (fall_s) begin
                  state_r <= ST_LOW;
                  h_lat_r <= cnt_r;
               end else if (timeout_hit_s) begin
                  state_r <= ST_IDLE;
                  timeout <= 1'b1;
               end
            end
            ST_LOW: begin
               if (rise_s) begin
                  state_r   <= ST_HIGH;
                  period    <= cnt_r;
                  high_time <= h_lat_r;
                  valid     <= 1'b1;
                  match     <= (cnt_r == EXP_PER_C) && (h_lat_r == EXP_HIGH_C);
                  timeout   <= 1'b0;
               end else if (timeout_hit_s) begin
                  state_r <= ST_IDLE;
                  timeout <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Self-checking bench for duty_cycle_meter. A timestamp-based reference
// model consumes each sampled sig_in value and pushes the output state the
// DUT should show two clocks later; every cycle one entry is popped and
// compared against the DUT outputs.
module tb_duty_cycle_meter;

   localparam int TO   = 64;
   localparam int EXPP = 5;
   localparam int EXPH = 2;

   logic       clockin = 1'b0;
   logic       reset   = 1'b1;
   logic       sig_in  = 1'b0;
   logic [7:0] period;
   logic [7:0] high_time;
   logic       valid;
   logic       match;
   logic       timeout;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       v;
      logic [7:0] p;
      logic [7:0] h;
      logic       m;
      logic       to;
   } exp_t;

   exp_t exp_q[$];

   // reference model state (timestamps in sample cycles)
   int         t;
   int         mstate;   // 0 idle, 1 high, 2 low
   logic       prev;
   int         last_rise;
   int         last_fall;
   int         last_edge;
   exp_t       cur;

   duty_cycle_meter #(.CNT_W(8), .TIMEOUT(TO), .EXP_PERIOD(EXPP), .EXP_HIGH(EXPH)) dut (
      .clockin  (clockin),
      .reset    (reset),
      .sig_in   (sig_in),
      .period   (period),
      .high_time(high_time),
      .valid    (valid),
      .match    (match),
      .timeout  (timeout)
   );

   always #5 clockin = ~clockin;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      t         = 0;
      mstate    = 0;
      prev      = 1'b0;
      last_rise = 0;
      last_fall = 0;
      last_edge = 0;
      cur       = '{v: 1'b0, p: 8'd0, h: 8'd0, m: 1'b0, to: 1'b0};
      exp_q.delete();
      exp_q.push_back(cur);
      exp_q.push_back(cur);
   endtask

   task automatic model_eval(input logic b);
      logic r;
      logic f;
      r     = b & ~prev;
      f     = ~b & prev;
      prev  = b;
      cur.v = 1'b0;
      if (r) begin
         if (mstate == 2) begin
            cur.v = 1'b1;
            cur.p = 8'(t - last_rise);
            cur.h = 8'(last_fall - last_rise);
            cur.m = ((t - last_rise) == EXPP) && ((last_fall - last_rise) == EXPH);
         end
         cur.to    = 1'b0;
         mstate    = 1;
         last_rise = t;
         last_edge = t;
      end else if (f) begin
         last_edge = t;
         if (mstate == 1) begin
            last_fall = t;
            mstate    = 2;
         end
      end else if (mstate != 0 && (t - last_edge) == TO) begin
         mstate = 0;
         cur.to = 1'b1;
      end
      t++;
      exp_q.push_back(cur);
   endtask

   task automatic step(input logic b);
      exp_t e;
      @(negedge clockin);
      sig_in = b;
      @(posedge clockin);
      model_eval(b);
      #1;
      chk("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("valid", 32'(valid), 32'(e.v));
         chk("period", 32'(period), 32'(e.p));
         chk("high_time", 32'(high_time), 32'(e.h));
         chk("match", 32'(match), 32'(e.m));
         chk("timeout", 32'(timeout), 32'(e.to));
      end
   endtask

   task automatic do_reset(input logic b);
      @(negedge clockin);
      reset  = 1'b1;
      sig_in = b;
      @(posedge clockin);
      #1;
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_period", 32'(period), 32'd0);
      chk("rst_high", 32'(high_time), 32'd0);
      chk("rst_match", 32'(match), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic run_pat(input logic [7:0] pat, input int len, input int reps);
      for (int r = 0; r < reps; r++) begin
         for (int i = len - 1; i >= 0; i--) begin
            step(pat[i]);
         end
      end
   endtask

   int vcount;

   initial begin
      // case 1: 0,0,1,1,0 -> period 5, high 2, match
      do_reset(1'b0);
      vcount = 0;
      for (int r = 0; r < 6; r++) begin
         for (int i = 4; i >= 0; i--) begin
            logic [4:0] pat1;
            pat1 = 5'b00110;
            step(pat1[i]);
            if (valid) vcount++;
         end
      end
      // six rises, first only arms
      chk("case1_valid_count", 32'(vcount), 32'd5);
      chk("case1_period", 32'(period), 32'd5);
      chk("case1_high", 32'(high_time), 32'd2);
      chk("case1_match", 32'(match), 32'd1);

      // case 4: stop toggling -> timeout, values hold; then restart
      for (int i = 0; i < 70; i++) step(1'b0);
      chk("case4_timeout", 32'(timeout), 32'd1);
      chk("case4_hold_period", 32'(period), 32'd5);
      chk("case4_hold_high", 32'(high_time), 32'd2);
      chk("case4_hold_match", 32'(match), 32'd1);
      run_pat(8'b00110, 5, 4);

      // case 5: reset mid-high during case 1 pattern
      step(1'b0);
      step(1'b0);
      step(1'b1);
      do_reset(1'b1);
      step(1'b1);
      step(1'b0);
      step(1'b0);
      run_pat(8'b00110, 5, 4);

      // case 2: 1,1,0,0 with sig_in held high across reset release
      do_reset(1'b1);
      run_pat(8'b1100, 4, 6);
      chk("case2_period", 32'(period), 32'd4);
      chk("case2_high", 32'(high_time), 32'd2);
      chk("case2_match", 32'(match), 32'd0);

      // case 3: fastest signal 1,0
      do_reset(1'b0);
      run_pat(8'b10, 2, 8);
      chk("case3_period", 32'(period), 32'd2);
      chk("case3_high", 32'(high_time), 32'd1);

      // case 6: single rise then low -> no valid, timeout
      do_reset(1'b0);
      vcount = 0;
      step(1'b1);
      for (int i = 0; i < 70; i++) begin
         step(1'b0);
         if (valid) vcount++;
      end
      chk("case6_no_valid", 32'(vcount), 32'd0);
      chk("case6_timeout", 32'(timeout), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
